// File: rtl/kmat_sub.sv
// k_mat builder: sweeps C and B'S RAMs word by word and writes M = C - B'S (mod 2^D) lane-wise.
// Optional KMAT_SUB_ADD_MODE_EN adds an i_add port selecting C + B'S instead.
module kmat_sub #(
    parameter int T         = 4,
    parameter int WQ        = 16,
    parameter int N_ENTRIES = 64,
    parameter int AW        = $clog2(N_ENTRIES / T)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_sec_level,
`ifdef KMAT_SUB_ADD_MODE_EN
    input  logic              i_add,
`endif
    output logic              o_rd_en,
    output logic [AW-1:0]     o_rd_addr,
    input  logic [T*WQ-1:0]   i_c,
    input  logic [T*WQ-1:0]   i_bs,
    output logic              o_k_mat_we,
    output logic [AW-1:0]     o_k_mat_addr,
    output logic [T*WQ-1:0]   o_k_mat,
    output logic              o_busy,
    output logic              o_done
);

    // state   | meaning
    // S_IDLE  | waiting for i_start; address 0 is read in the accept cycle
    // S_READ  | issuing reads for addresses 1..LAST
    // S_DRAIN | reads finished, waiting for the write of LAST
    // S_DONE  | one-cycle completion pulse
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [AW-1:0] LAST = AW'(N_ENTRIES / T - 1);

    logic [1:0]      state;
    logic [AW-1:0]   rd_addr;
    logic [2:0]      sec_q;
    logic            add_q;
    logic            v1;
    logic [AW-1:0]   a1;
    logic [T*WQ-1:0] d_word;
    logic            accept;
    logic            wide;

    assign accept    = (state == S_IDLE) && i_start;
    assign o_rd_en   = (state == S_READ) || (accept && !i_rst);
    assign o_rd_addr = rd_addr;
    assign o_busy    = (state == S_READ) || (state == S_DRAIN);
    assign o_done    = (state == S_DONE);
    assign wide      = (sec_q != 3'd1);

`ifndef KMAT_SUB_ADD_MODE_EN
    assign add_q = 1'b0;
`endif

    always_comb begin
        d_word = '0;
        for (int i = 0; i < T; i++) begin
            logic [WQ-1:0] lane;
            lane = add_q ? (i_c[i*WQ +: WQ] + i_bs[i*WQ +: WQ])
                         : (i_c[i*WQ +: WQ] - i_bs[i*WQ +: WQ]);
            // level 1 uses a 15-bit q, so the top bit is dropped
            if (!wide) lane[WQ-1] = 1'b0;
            d_word[i*WQ +: WQ] = lane;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            rd_addr      <= '0;
            sec_q        <= 3'd1;
            v1           <= 1'b0;
            a1           <= '0;
            o_k_mat_we   <= 1'b0;
            o_k_mat_addr <= '0;
            o_k_mat      <= '0;
        end else begin
            v1           <= o_rd_en;
            a1           <= o_rd_addr;
            o_k_mat_we   <= v1;
            o_k_mat_addr <= a1;
            o_k_mat      <= d_word;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        sec_q   <= (i_sec_level == 3'd3 || i_sec_level == 3'd5) ? i_sec_level : 3'd1;
                        rd_addr <= AW'(1);
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_addr == LAST) begin
                        rd_addr <= '0;
                        state   <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + AW'(1);
                    end
                end
                S_DRAIN: begin
                    if (o_k_mat_we && (o_k_mat_addr == LAST)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef KMAT_SUB_ADD_MODE_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            add_q <= 1'b0;
        else if (accept)
            add_q <= i_add;
    end
`endif

endmodule

// File: doc/kmat_sub.md
Name: kmat_sub

Overview:
- Decapsulation stage that builds the k_mat RAM read by the decode stage: M = C − B'S (mod q).
- Sweeps the mbar×nbar matrix T entries per word. Reads C and the B'S product word-by-word from two RAMs, subtracts lane-wise mod q, and writes the result word to k_mat RAM at the same address.
- The decode stage is started after o_done.

Parameters:
- T, 4, entries per RAM word (matches decode parallelism).
- WQ, 16, bits per entry lane (L5 width of q).
- N_ENTRIES, 64, matrix entries (mbar*nbar).
- AW, clog2(N_ENTRIES/T)=4, RAM address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle start pulse.
- i_sec_level  in  3  1, 3 or 5; sampled at start.
- o_rd_en  out  1  read enable for both C and B'S RAMs.
- o_rd_addr  out  AW  shared read address.
- i_c  in  T*WQ  C word, valid 1 cycle after o_rd_en.
- i_bs  in  T*WQ  B'S word, valid 1 cycle after o_rd_en.
- o_k_mat_we  out  1  k_mat RAM write enable.
- o_k_mat_addr  out  AW  k_mat write address.
- o_k_mat  out  T*WQ  k_mat write data.
- o_busy  out  1  high from accepted start until done.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, i_rst=1): every output 0, state S_IDLE, all counters and pipeline registers cleared. Reset mid-sweep aborts immediately; no further writes are issued and no done pulse follows.
- States: S_IDLE, S_READ, S_DRAIN, S_DONE.
- S_IDLE:
  - i_start=1 → latch i_sec_level into sec_q, assert o_rd_en with o_rd_addr=0 combinationally in the same cycle, go to S_READ with rd_addr=1 registered.
  - Unsupported sec_level (not 1/3/5) is treated as 1.
- S_READ:
  - o_rd_en=1 and o_rd_addr increments each cycle.
  - When the address N_ENTRIES/T−1 has been issued, go to S_DRAIN.
  - o_rd_addr returns to 0 on leaving S_READ.
- Pipeline:
  - Stage 1 (cycle after read): lane i computes d_i = i_c[i] − i_bs[i] modulo 2^WQ, then masks to D bits. D=15 when sec_q=1, else D=16; the upper bits are zeroed.
  - Stage 2: the registered d word drives o_k_mat with o_k_mat_we=1 and o_k_mat_addr equal to the read address delayed by 2 cycles.
  - Read-to-write latency: 2 cycles. Write of address a occurs 2 cycles after read of a.
- S_DRAIN: waits until the last write (address N_ENTRIES/T−1) has been issued, then goes to S_DONE.
- S_DONE: o_done=1 for exactly one cycle, o_busy drops in the same cycle, return to S_IDLE.
- Total: start to done = N_ENTRIES/T + 2 cycles (18 at defaults).
- o_busy=1 from the cycle after start through the cycle before o_done.
- i_start while busy is ignored; no restart or queueing. i_start in the S_DONE cycle is also ignored. i_start in the following S_IDLE cycle is accepted (back-to-back runs).
- Subtraction wraps: C < B'S yields (C − B'S + 2^D) masked. No saturation.
- The address counter never wraps past N_ENTRIES/T−1 within a run.

Optional Feature:
- Macro KMAT_SUB_ADD_MODE_EN.
- When defined: adds input port i_add (1 bit, sampled with i_start into add_q). add_q=1 computes d_i = i_c[i] + i_bs[i] (mod 2^D) so the block is reusable for V = B'S' + C2 in encapsulation. add_q=0 behaves as subtraction.
- When undefined: no i_add port; subtraction only. Timing is identical in both builds.

Test Plan:
- Level 5, C lanes all 16'h1234, B'S all 16'h0034 → 16 writes, addresses 0..15, each word {4{16'h1200}}; o_done 18 cycles after start.
- Level 5 wrap: C=16'h0001, B'S=16'h0002 → lane 16'hFFFF. Level 1 same inputs → 16'h7FFF (bit 15 masked).
- Latency check: start at cycle t → o_rd_en cycles t..t+15, o_k_mat_we cycles t+2..t+17, o_done at t+18, o_busy high t+1..t+17.
- Assert i_start at t+5 mid-run and at the S_DONE cycle → ignored (no address reset, exactly 16 writes). Start at t+19 → second full run.
- Assert i_rst at t+7 → outputs 0 asynchronously, no writes after t+7, no o_done; a new start afterward produces a clean full run.
- With KMAT_SUB_ADD_MODE_EN, i_add=1, level 3: C=16'hFFF0, B'S=16'h0020 → lane 16'h0010.
